// File: rtl/sp_stack_ctrl.sv
// Full-descending stack pointer owner issuing word push/pop over a mem_req/mem_ack handshake.
// Latency: mem_req one cycle after acceptance, done one cycle after mem_ack; requests are ignored (not queued) while busy.
module sp_stack_ctrl #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   SP_INIT  = N'(32'h100103FC),
  parameter logic [N-1:0]   SP_LIMIT = N'(32'h10010000)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_req,
  input  logic         pop_req,
  input  logic [N-1:0] push_data,
  input  logic         sp_wr_en,
  input  logic [N-1:0] sp_wr_data,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [N-1:0] sp_value,
  output logic [N-1:0] pop_data,
  output logic         busy,
  output logic         done,
  output logic         overflow_err,
  output logic         underflow_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] WORD = N'(4);

  state_t       state, state_n;
  logic [N-1:0] sp_n, pop_data_n, mem_addr_n, mem_wdata_n;
  logic         mem_req_n, mem_we_n, done_n, ovf_n, unf_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sp_value      <= SP_INIT;
      pop_data      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state         <= state_n;
      sp_value      <= sp_n;
      pop_data      <= pop_data_n;
      mem_req       <= mem_req_n;
      mem_we        <= mem_we_n;
      mem_addr      <= mem_addr_n;
      mem_wdata     <= mem_wdata_n;
      busy          <= (state_n != IDLE);
      done          <= done_n;
      overflow_err  <= ovf_n;
      underflow_err <= unf_n;
    end
  end

  // Every output is computed one cycle ahead here so that all of them leave the block registered.
  always_comb begin
    state_n     = state;
    sp_n        = sp_value;
    pop_data_n  = pop_data;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    done_n      = 1'b0;
    ovf_n       = 1'b0;
    unf_n       = 1'b0;

    case (state)
      IDLE: begin
        if (sp_wr_en) begin
          sp_n = {sp_wr_data[N-1:2], 2'b00};
        end else if (push_req) begin
          if (sp_value == SP_LIMIT) begin
            ovf_n = 1'b1;
          end else begin
            state_n     = WRITE;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = sp_value - WORD;
            mem_wdata_n = push_data;
          end
        end else if (pop_req) begin
          if (sp_value == SP_INIT) begin
            unf_n = 1'b1;
          end else begin
            state_n    = READ;
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = sp_value;
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          sp_n      = sp_value - WORD;
          mem_req_n = 1'b0;
          done_n    = 1'b1;
          state_n   = DONE;
        end
      end
      READ: begin
        if (mem_ack) begin
          pop_data_n = mem_rdata;
          sp_n       = sp_value + WORD;
          mem_req_n  = 1'b0;
          done_n     = 1'b1;
          state_n    = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sp_stack_ctrl.sv
// Directed bench for sp_stack_ctrl: push/pop handshakes, error pulses, priority and async reset abort.
module tb_sp_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_req, pop_req, sp_wr_en, mem_ack;
  logic [31:0] push_data, sp_wr_data, mem_rdata;
  logic        mem_req, mem_we, busy, done, overflow_err, underflow_err;
  logic [31:0] mem_addr, mem_wdata, sp_value, pop_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sp_stack_ctrl dut (
    .clk(clk), .reset(reset),
    .push_req(push_req), .pop_req(pop_req), .push_data(push_data),
    .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sp_value(sp_value), .pop_data(pop_data), .busy(busy), .done(done),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; push_req = 0; pop_req = 0; sp_wr_en = 0; mem_ack = 0;
    push_data = '0; sp_wr_data = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_sp", sp_value, 32'h100103FC);
    chk("rst_pop_data", pop_data, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_flags", {28'b0, busy, done, overflow_err, underflow_err}, 32'h0);
    reset = 1'b1;
    tick();

    // push with ack in the first request cycle
    push_req = 1; push_data = 32'hDEADBEEF;
    tick();
    chk("push_req", {31'b0, mem_req}, 32'h1);
    chk("push_we", {31'b0, mem_we}, 32'h1);
    chk("push_addr", mem_addr, 32'h100103F8);
    chk("push_wdata", mem_wdata, 32'hDEADBEEF);
    chk("push_busy", {31'b0, busy}, 32'h1);
    push_req = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("push_done", {31'b0, done}, 32'h1);
    chk("push_req_drop", {31'b0, mem_req}, 32'h0);
    chk("push_sp", sp_value, 32'h100103F8);
    tick();
    chk("push_done_end", {31'b0, done}, 32'h0);
    chk("push_idle", {31'b0, busy}, 32'h0);

    // pop with ack delayed three cycles
    pop_req = 1;
    tick();
    pop_req = 0;
    chk("pop_we", {31'b0, mem_we}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("pop_req_hold", {31'b0, mem_req}, 32'h1);
      chk("pop_addr_hold", mem_addr, 32'h100103F8);
      tick();
    end
    chk("pop_req_4th", {31'b0, mem_req}, 32'h1);
    chk("pop_no_early_done", {31'b0, done}, 32'h0);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0; mem_rdata = '0;
    chk("pop_done", {31'b0, done}, 32'h1);
    chk("pop_data", pop_data, 32'hDEADBEEF);
    chk("pop_sp", sp_value, 32'h100103FC);
    tick();
    chk("pop_done_end", {31'b0, done}, 32'h0);

    // underflow after a fresh reset
    reset = 0; #2; reset = 1;
    pop_req = 1;
    tick();
    pop_req = 0;
    chk("unf_pulse", {31'b0, underflow_err}, 32'h1);
    chk("unf_no_req", {31'b0, mem_req}, 32'h0);
    chk("unf_sp", sp_value, 32'h100103FC);
    tick();
    chk("unf_pulse_end", {31'b0, underflow_err}, 32'h0);
    chk("unf_still_idle", {31'b0, mem_req}, 32'h0);

    // aligned SP load, then push at the limit overflows
    sp_wr_en = 1; sp_wr_data = 32'h10010003;
    tick();
    sp_wr_en = 0;
    chk("spwr_sp", sp_value, 32'h10010000);
    chk("spwr_no_done", {31'b0, done}, 32'h0);
    push_req = 1;
    tick();
    push_req = 0;
    chk("ovf_pulse", {31'b0, overflow_err}, 32'h1);
    chk("ovf_no_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("ovf_pulse_end", {31'b0, overflow_err}, 32'h0);
    chk("ovf_sp", sp_value, 32'h10010000);

    // sp_wr_en wins over a simultaneous push
    sp_wr_en = 1; sp_wr_data = 32'h100103F8; push_req = 1;
    tick();
    sp_wr_en = 0; push_req = 0;
    chk("prio_spwr_sp", sp_value, 32'h100103F8);
    chk("prio_spwr_no_req", {31'b0, mem_req}, 32'h0);

    // push and pop together: push first, held pop afterwards
    push_req = 1; pop_req = 1; push_data = 32'hCAFEF00D;
    tick();
    push_req = 0;
    chk("both_push_we", {31'b0, mem_we}, 32'h1);
    chk("both_push_addr", mem_addr, 32'h100103F4);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("both_push_done", {31'b0, done}, 32'h1);
    chk("both_push_sp", sp_value, 32'h100103F4);
    tick();
    chk("both_idle_no_req", {31'b0, mem_req}, 32'h0);
    chk("both_idle", {31'b0, busy}, 32'h0);
    tick();
    pop_req = 0;
    chk("both_pop_req", {31'b0, mem_req}, 32'h1);
    chk("both_pop_we", {31'b0, mem_we}, 32'h0);
    chk("both_pop_addr", mem_addr, 32'h100103F4);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    chk("both_pop_data", pop_data, 32'hCAFEF00D);
    chk("both_pop_sp", sp_value, 32'h100103F8);
    tick();

    // reset while a write waits for ack
    push_req = 1; push_data = 32'h12345678;
    tick();
    push_req = 0;
    chk("abort_req", {31'b0, mem_req}, 32'h1);
    tick();
    chk("abort_wait", {31'b0, mem_req}, 32'h1);
    #2 reset = 0;
    #1;
    chk("abort_req_drop", {31'b0, mem_req}, 32'h0);
    chk("abort_sp", sp_value, 32'h100103FC);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    #1 reset = 1;
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("late_ack_no_done", {31'b0, done}, 32'h0);
    chk("late_ack_no_req", {31'b0, mem_req}, 32'h0);
    chk("late_ack_sp", sp_value, 32'h100103FC);
    tick();
    chk("late_ack_idle", {30'b0, busy, done}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_stack_ctrl.md
Name: sp_stack_ctrl

Overview:
- Sequencer that owns the stack pointer and performs word push/pop transactions to data memory through a req/ack handshake.
- Sits between the core's stack-operation requests and the data-memory port.
- Holds SP; detects overflow against a lower limit and underflow against the initial top.
- Also accepts direct SP writes from register-file write-back.

Parameters:
- N, 32: data/address width.
- SP_INIT, 32'h100103FC: SP reset value and empty-stack value (top of data memory).
- SP_LIMIT, 32'h10010000: lowest legal SP; stack is full when SP == SP_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push_req  in  1  level request to push push_data; sampled only in IDLE.
- pop_req  in  1  level request to pop; sampled only in IDLE.
- push_data  in  N  word to push; captured when push is accepted.
- sp_wr_en  in  1  direct SP load request.
- sp_wr_data  in  N  new SP value for sp_wr_en.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  N  read data, valid with mem_ack on reads.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  N  word address.
- mem_wdata  out  N  write data.
- sp_value  out  N  current SP.
- pop_data  out  N  last popped word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a push or pop completes.
- overflow_err  out  1  one-cycle pulse when a push is rejected.
- underflow_err  out  1  one-cycle pulse when a pop is rejected.

Behaviour:
- Reset values (asynchronous, active-low):
  - sp_value = SP_INIT; pop_data = 0.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - busy, done, overflow_err, underflow_err = 0.
  - State = IDLE.
- All outputs are registered.
- Stack convention: full-descending.
  - Push: write at SP-4, then SP -= 4.
  - Pop: read at SP, then SP += 4.
  - Empty when SP == SP_INIT.
- States: IDLE, WRITE, READ, DONE.
- IDLE, request priority is sp_wr_en > push_req > pop_req:
  - sp_wr_en: SP <= {sp_wr_data[N-1:2], 2'b00} next cycle; stay IDLE; no done pulse.
  - push_req with SP == SP_LIMIT: overflow_err pulses next cycle; SP unchanged; stay IDLE.
  - push_req otherwise: latch push_data; go to WRITE with mem_req=1, mem_we=1, mem_addr=SP-4, mem_wdata=push_data.
  - pop_req with SP == SP_INIT: underflow_err pulses next cycle; stay IDLE.
  - pop_req otherwise: go to READ with mem_req=1, mem_we=0, mem_addr=SP.
- WRITE:
  - Hold mem_req and mem_addr/mem_wdata stable until mem_ack.
  - On mem_ack: SP <= SP-4, mem_req <= 0, go to DONE.
- READ:
  - Hold mem_req until mem_ack.
  - On mem_ack: pop_data <= mem_rdata, SP <= SP+4, mem_req <= 0, go to DONE.
- DONE: done=1 for exactly one cycle; new sp_value visible; return to IDLE.
- While busy, sp_wr_en, push_req and pop_req are ignored (not queued). Requesters hold their level until done or an err pulse.
- Minimum latency with mem_ack in the first req cycle:
  - Request sampled at edge 0; mem_req high cycle 1; done cycle 2; IDLE cycle 3.
  - Back-to-back accepted operations are therefore spaced 3 cycles apart.
- No wait limit on mem_ack; the FSM waits indefinitely.
- mem_ack in IDLE or DONE is ignored.
- SP arithmetic is modulo 2^N. Overflow/underflow checks use equality only, so software must load aligned SP values within [SP_LIMIT, SP_INIT].
- Reset mid-transaction: mem_req drops immediately (async); SP returns to SP_INIT; the in-flight operation is abandoned and no done pulse is issued.

Test Plan:
- Reset, then push_req with push_data=32'hDEADBEEF, mem_ack in the first req cycle -> mem_addr=32'h100103F8, mem_we=1, done in cycle 2, sp_value=32'h100103F8.
- Pop after that push, mem_rdata=32'hDEADBEEF with ack delayed 3 cycles -> mem_req held 4 cycles at addr 32'h100103F8, pop_data=32'hDEADBEEF, sp_value=32'h100103FC.
- pop_req right after reset -> underflow_err one-cycle pulse, no mem_req, sp_value stays 32'h100103FC.
- sp_wr_en with sp_wr_data=32'h10010003, then push_req -> SP loads 32'h10010000; push gives overflow_err pulse, no mem_req.
- push_req and pop_req asserted together at SP=32'h100103F8 -> push serviced (addr 32'h100103F4); pop serviced only after done, if still held.
- Reset asserted while in WRITE awaiting ack -> mem_req=0 immediately, sp_value=32'h100103FC, no done pulse; after reset release, a late mem_ack is ignored.
